// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_router block.
package demux_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_SEL_W  = 2;
  localparam int DEFAULT_CNT_W  = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_router_if.sv
// Shared-bus input and per-channel output bundle of demux_router.
interface demux_router_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int SEL_W  = DEFAULT_SEL_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) ();

  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*CNT_W-1:0]  out_cnt;
  logic                     err;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_cnt, err
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_cnt, err
  );

endinterface

// File: rtl/demux_router_slot.sv
// One-entry holding slot with a delivered-word counter; the top only loads
// a slot that is empty or being drained in the same cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  input  logic              ready,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  output logic [CNT_W-1:0]  cnt
);

  slot_state_e       state_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (load) begin
            state_q <= SLOT_FULL;
            data_q  <= d;
          end
        end
        SLOT_FULL: begin
          // A drain counts even when a new word replaces it in the same cycle.
          if (load) begin
            data_q <= d;
          end else if (ready) begin
            state_q <= SLOT_EMPTY;
          end
          if (ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign q     = data_q;
  assign valid = (state_q == SLOT_FULL);
  assign cnt   = cnt_q;

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-NUM_CH demultiplexer with valid/ready flow control and
// per-channel holding slots; out-of-range selects are dropped and flagged.
module demux_router
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int SEL_W  = DEFAULT_SEL_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input logic           clk,
  input logic           rst,
  demux_router_if.slave bus
);

  if (SEL_W < clog2(NUM_CH)) begin : g_sel_w_chk
    $error("demux_router: SEL_W too narrow for NUM_CH");
  end
  if ((NUM_CH < 2) || (NUM_CH > 16)) begin : g_num_ch_chk
    $error("demux_router: NUM_CH must be in 2..16");
  end

  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic                     in_range;
  logic                     sel_free;
  logic                     in_ready_s;
  logic                     accept;
  logic [NUM_CH-1:0]        load_vec;
  logic [NUM_CH-1:0]        valid_vec;
  logic [NUM_CH*DATA_W-1:0] data_vec;
  logic [NUM_CH*CNT_W-1:0]  cnt_vec;
  logic                     err_q;

  assign in_range   = ({1'b0, bus.in_sel} < NUM_CH_W);
  assign in_ready_s = rst ? 1'b0 : (in_range ? sel_free : 1'b1);
  assign accept     = bus.in_valid & in_ready_s;

  // Selected-slot availability and one-hot load decode.
  always_comb begin
    sel_free = 1'b0;
    load_vec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_free    = ~valid_vec[k] | bus.out_ready[k];
        load_vec[k] = accept;
      end else begin
        load_vec[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & ~in_range;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load_vec[g]),
      .d     (bus.in_data),
      .ready (bus.out_ready[g]),
      .q     (data_vec[g*DATA_W +: DATA_W]),
      .valid (valid_vec[g]),
      .cnt   (cnt_vec[g*CNT_W +: CNT_W])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_vec;
  assign bus.out_data  = data_vec;
  assign bus.out_cnt   = cnt_vec;
  assign bus.err       = err_q;

endmodule
